// File: rtl/csr_commit_unit.sv
// Writeback-side machine-mode CSR file, privilege tracking and trap/mret fetch redirect.
// Optional mcycle/minstret counters are enabled by defining CSR_COUNTERS_EN.
module csr_commit_unit #(
   parameter logic [63:0] MTVEC_RESET   = 64'h0,
   parameter logic [63:0] MSTATUS_RESET = 64'h0,
   parameter logic [1:0]  PRIV_RESET    = 2'b11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic        wb_csr_we,
   input  logic [11:0] wb_csr_addr,
   input  logic [63:0] wb_csr_wdata,
   input  logic        wb_trap,
   input  logic        wb_mret,
   input  logic [63:0] wb_pc,
   input  logic [63:0] wb_mcause,
   input  logic [63:0] wb_mstatus_new,
   input  logic [1:0]  wb_priv_new,
   input  logic [11:0] rd_addr,
   output logic [63:0] rd_data,
   output logic [63:0] mstatus_out,
   output logic [1:0]  priv_mode,
   output logic        wb_stall,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   input  logic        redirect_ready
);
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;

   typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [63:0] r_mstatus;
   logic [63:0] r_mtvec;
   logic [63:0] r_mepc;
   logic [63:0] r_mcause;
   logic [63:0] r_mscratch;
   logic [63:0] r_mie;
   logic [63:0] r_mip;
   logic [63:0] r_redirect_pc;
   logic [1:0]  r_priv;
   logic        w_accept;
   logic        w_trap;
   logic        w_mret;
   logic        w_csr_wr;

   // Priority: trap beats mret beats CSR write; nothing is accepted while redirecting.
   assign w_accept = (r_state == IDLE) && wb_valid;
   assign w_trap   = w_accept && wb_trap;
   assign w_mret   = w_accept && !wb_trap && wb_mret;
   assign w_csr_wr = w_accept && !wb_trap && !wb_mret && wb_csr_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:     if (w_trap || w_mret) w_state_next = REDIRECT;
         REDIRECT: if (redirect_ready) w_state_next = IDLE;
         default:  w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mstatus     <= MSTATUS_RESET;
         r_mtvec       <= MTVEC_RESET;
         r_mepc        <= 64'h0;
         r_mcause      <= 64'h0;
         r_mscratch    <= 64'h0;
         r_mie         <= 64'h0;
         r_mip         <= 64'h0;
         r_priv        <= PRIV_RESET;
         r_redirect_pc <= 64'h0;
      end else if (w_trap) begin
         r_mepc        <= wb_pc;
         r_mcause      <= wb_mcause;
         r_mstatus     <= wb_mstatus_new;
         r_priv        <= wb_priv_new;
         r_redirect_pc <= {r_mtvec[63:2], 2'b00};
      end else if (w_mret) begin
         r_mstatus     <= wb_mstatus_new;
         r_priv        <= wb_priv_new;
         r_redirect_pc <= r_mepc;
      end else if (w_csr_wr) begin
         case (wb_csr_addr)
            A_MSTATUS:  r_mstatus  <= wb_csr_wdata;
            A_MIE:      r_mie      <= wb_csr_wdata;
            A_MTVEC:    r_mtvec    <= wb_csr_wdata;
            A_MSCRATCH: r_mscratch <= wb_csr_wdata;
            A_MEPC:     r_mepc     <= {wb_csr_wdata[63:2], 2'b00};
            A_MCAUSE:   r_mcause   <= wb_csr_wdata;
            A_MIP:      r_mip      <= wb_csr_wdata;
            default:    ;
         endcase
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;

   // A software write in the same cycle takes precedence over the increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mcycle   <= 64'h0;
         r_minstret <= 64'h0;
      end else begin
         if (w_csr_wr && (wb_csr_addr == A_MCYCLE)) r_mcycle <= wb_csr_wdata;
         else                                       r_mcycle <= r_mcycle + 64'd1;
         if (w_csr_wr && (wb_csr_addr == A_MINSTRET)) r_minstret <= wb_csr_wdata;
         else if (w_accept)                           r_minstret <= r_minstret + 64'd1;
      end
   end
`endif

   always_comb begin
      rd_data = 64'h0;
      case (rd_addr)
         A_MSTATUS:  rd_data = r_mstatus;
         A_MIE:      rd_data = r_mie;
         A_MTVEC:    rd_data = r_mtvec;
         A_MSCRATCH: rd_data = r_mscratch;
         A_MEPC:     rd_data = r_mepc;
         A_MCAUSE:   rd_data = r_mcause;
         A_MIP:      rd_data = r_mip;
`ifdef CSR_COUNTERS_EN
         A_MCYCLE:   rd_data = r_mcycle;
         A_MINSTRET: rd_data = r_minstret;
`endif
         default:    rd_data = 64'h0;
      endcase
   end

   // Handshake: redirect_valid/redirect_pc stay stable until a cycle with redirect_ready high.
   assign redirect_valid = (r_state == REDIRECT);
   assign wb_stall       = (r_state == REDIRECT);
   assign redirect_pc    = r_redirect_pc;
   assign mstatus_out    = r_mstatus;
   assign priv_mode      = r_priv;
endmodule

// File: tb/tb_csr_commit_unit.sv
// Directed bench for csr_commit_unit: array-based CSR model checked every cycle plus literal pins.
module tb_csr_commit_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid, wb_csr_we, wb_trap, wb_mret, redirect_ready;
   logic [11:0] wb_csr_addr, rd_addr;
   logic [63:0] wb_csr_wdata, wb_pc, wb_mcause, wb_mstatus_new;
   logic [1:0]  wb_priv_new;
   logic [63:0] rd_data, mstatus_out, redirect_pc;
   logic [1:0]  priv_mode;
   logic        wb_stall, redirect_valid;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   csr_commit_unit dut (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_csr_we(wb_csr_we),
      .wb_csr_addr(wb_csr_addr), .wb_csr_wdata(wb_csr_wdata), .wb_trap(wb_trap),
      .wb_mret(wb_mret), .wb_pc(wb_pc), .wb_mcause(wb_mcause),
      .wb_mstatus_new(wb_mstatus_new), .wb_priv_new(wb_priv_new), .rd_addr(rd_addr),
      .rd_data(rd_data), .mstatus_out(mstatus_out), .priv_mode(priv_mode),
      .wb_stall(wb_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: flat CSR array indexed by address, unknown addresses stay 0.
   logic [63:0] m_csr [0:4095];
   logic [1:0]  m_priv;
   logic        m_pend;
   logic [63:0] m_rpc;
   logic        m_commit, m_wr;

   function automatic logic known(input logic [11:0] a);
      logic k;
      k = (a == 12'h300) || (a == 12'h304) || (a == 12'h305) || (a == 12'h340) ||
          (a == 12'h341) || (a == 12'h342) || (a == 12'h344);
`ifdef CSR_COUNTERS_EN
      if ((a == 12'hB00) || (a == 12'hB02)) k = 1'b1;
`endif
      return k;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4096; i++) m_csr[i] = 64'h0;
         m_priv = 2'b11;
         m_pend = 1'b0;
         m_rpc  = 64'h0;
      end else begin
         m_commit = !m_pend && wb_valid;
         m_wr     = m_commit && !wb_trap && !wb_mret && wb_csr_we && known(wb_csr_addr);
         if (m_pend) begin
            if (redirect_ready) m_pend = 1'b0;
         end else if (m_commit && wb_trap) begin
            m_rpc            = m_csr[12'h305] & ~64'h3;
            m_csr[12'h341]   = wb_pc;
            m_csr[12'h342]   = wb_mcause;
            m_csr[12'h300]   = wb_mstatus_new;
            m_priv           = wb_priv_new;
            m_pend           = 1'b1;
         end else if (m_commit && wb_mret) begin
            m_rpc            = m_csr[12'h341];
            m_csr[12'h300]   = wb_mstatus_new;
            m_priv           = wb_priv_new;
            m_pend           = 1'b1;
         end else if (m_wr) begin
            m_csr[wb_csr_addr] = (wb_csr_addr == 12'h341) ? (wb_csr_wdata & ~64'h3) : wb_csr_wdata;
         end
`ifdef CSR_COUNTERS_EN
         if (!(m_wr && wb_csr_addr == 12'hB00)) m_csr[12'hB00] = m_csr[12'hB00] + 64'd1;
         if (!(m_wr && wb_csr_addr == 12'hB02) && m_commit) m_csr[12'hB02] = m_csr[12'hB02] + 64'd1;
`endif
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         check("cmp_rd_data", rd_data, m_csr[rd_addr]);
         check("cmp_mstatus", mstatus_out, m_csr[12'h300]);
         check("cmp_priv", {62'h0, priv_mode}, {62'h0, m_priv});
         check("cmp_redirect_valid", {63'h0, redirect_valid}, {63'h0, m_pend});
         check("cmp_wb_stall", {63'h0, wb_stall}, {63'h0, m_pend});
         check("cmp_redirect_pc", redirect_pc, m_rpc);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wb_valid = 0; wb_csr_we = 0; wb_trap = 0; wb_mret = 0;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
      idle_in();
      wb_valid = 1; wb_csr_we = 1; wb_csr_addr = a; wb_csr_wdata = d;
      cyc();
      idle_in();
   endtask

   task automatic do_trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] mst,
                          input logic [1:0] pv, input logic we, input logic [11:0] wa,
                          input logic [63:0] wd);
      idle_in();
      wb_valid = 1; wb_trap = 1; wb_pc = pc; wb_mcause = cause; wb_mstatus_new = mst;
      wb_priv_new = pv; wb_csr_we = we; wb_csr_addr = wa; wb_csr_wdata = wd;
      cyc();
      idle_in();
   endtask

   task automatic do_mret(input logic [63:0] mst, input logic [1:0] pv);
      idle_in();
      wb_valid = 1; wb_mret = 1; wb_mstatus_new = mst; wb_priv_new = pv;
      cyc();
      idle_in();
   endtask

   task automatic rd_chk(input string name, input logic [11:0] a, input logic [63:0] exp);
      rd_addr = a;
      #1;
      check(name, rd_data, exp);
   endtask

   task automatic release_redirect();
      redirect_ready = 1;
      cyc();
      redirect_ready = 0;
      check("release_valid", {63'h0, redirect_valid}, 64'h0);
      check("release_stall", {63'h0, wb_stall}, 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1; redirect_ready = 0; rd_addr = 12'h0;
      wb_csr_addr = 12'h0; wb_csr_wdata = 64'h0; wb_pc = 64'h0; wb_mcause = 64'h0;
      wb_mstatus_new = 64'h0; wb_priv_new = 2'b00;
      idle_in();
      repeat (2) cyc();
      reset = 0;
      cyc();
      check("rst_mstatus", mstatus_out, 64'h0);
      check("rst_priv", {62'h0, priv_mode}, 64'h3);
      check("rst_redirect_valid", {63'h0, redirect_valid}, 64'h0);
      rd_chk("rst_mtvec", 12'h305, 64'h0);

      // mtvec then ecall trap
      csr_write(12'h305, 64'h8000_0100);
      rd_chk("mtvec_wr", 12'h305, 64'h8000_0100);
      do_trap(64'h8000_0040, 64'd8, 64'h1800, 2'b11, 1'b0, 12'h0, 64'h0);
      check("trap_valid", {63'h0, redirect_valid}, 64'h1);
      check("trap_pc", redirect_pc, 64'h8000_0100);
      check("trap_stall", {63'h0, wb_stall}, 64'h1);
      check("trap_mstatus", mstatus_out, 64'h1800);
      rd_chk("trap_mepc", 12'h341, 64'h8000_0040);
      rd_chk("trap_mcause", 12'h342, 64'd8);

      // Hold for three cycles; a write arriving while stalled is ignored
      wb_valid = 1; wb_csr_we = 1; wb_csr_addr = 12'h340; wb_csr_wdata = 64'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         cyc();
         idle_in();
         check("hold_valid", {63'h0, redirect_valid}, 64'h1);
         check("hold_pc", redirect_pc, 64'h8000_0100);
         check("hold_stall", {63'h0, wb_stall}, 64'h1);
      end
      rd_chk("hold_mscratch", 12'h340, 64'h0);
      release_redirect();

      // mepc low bits forced to zero, then mret
      csr_write(12'h341, 64'h8000_0047);
      rd_chk("mepc_align", 12'h341, 64'h8000_0044);
      do_mret(64'h80, 2'b00);
      check("mret_pc", redirect_pc, 64'h8000_0044);
      check("mret_priv", {62'h0, priv_mode}, 64'h0);
      check("mret_mstatus", mstatus_out, 64'h80);
      release_redirect();

      // Trap suppresses a same-cycle CSR write
      do_trap(64'h8000_0200, 64'd11, 64'h1880, 2'b11, 1'b1, 12'h340, 64'h1234);
      check("trapwe_pc", redirect_pc, 64'h8000_0100);
      check("trapwe_priv", {62'h0, priv_mode}, 64'h3);
      rd_chk("trapwe_mscratch", 12'h340, 64'h0);
      rd_chk("trapwe_mcause", 12'h342, 64'd11);

      // Asynchronous reset in the middle of a pending redirect
      @(posedge clk);
      #3;
      reset = 1;
      #1;
      check("arst_valid", {63'h0, redirect_valid}, 64'h0);
      check("arst_stall", {63'h0, wb_stall}, 64'h0);
      check("arst_mstatus", mstatus_out, 64'h0);
      check("arst_priv", {62'h0, priv_mode}, 64'h3);
      check("arst_pc", redirect_pc, 64'h0);
      rd_chk("arst_mtvec", 12'h305, 64'h0);
      cyc();
      reset = 0;
      cyc();

      // Misc CSRs, unknown address, mtvec mode bits masked on trap
      csr_write(12'h7C0, 64'h5);
      rd_chk("unknown_rd", 12'h7C0, 64'h0);
      csr_write(12'h304, 64'h888);
      rd_chk("mie_wr", 12'h304, 64'h888);
      csr_write(12'h344, 64'h80);
      rd_chk("mip_wr", 12'h344, 64'h80);
      csr_write(12'h340, 64'hCAFE_F00D_1234_5678);
      rd_chk("mscratch_wr", 12'h340, 64'hCAFE_F00D_1234_5678);
      csr_write(12'h305, 64'h8000_1003);
      do_trap(64'h8000_0300, 64'd11, 64'h0, 2'b11, 1'b0, 12'h0, 64'h0);
      check("mtvec_mask_pc", redirect_pc, 64'h8000_1000);
      release_redirect();

`ifdef CSR_COUNTERS_EN
      csr_write(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
      rd_chk("mcycle_wr", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
      cyc();
      rd_chk("mcycle_wrap", 12'hB00, 64'h0);
      csr_write(12'hB02, 64'h0);
      rd_chk("minstret_clr", 12'hB02, 64'h0);
      wb_valid = 1;
      repeat (5) cyc();
      idle_in();
      rd_chk("minstret_5", 12'hB02, 64'd5);
`else
      csr_write(12'hB00, 64'h5);
      rd_chk("mcycle_absent", 12'hB00, 64'h0);
      csr_write(12'hB02, 64'h5);
      rd_chk("minstret_absent", 12'hB02, 64'h0);
`endif
      repeat (3) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/csr_commit_unit.md
Name: csr_commit_unit

Overview:
- Writeback-side consumer of the execute-stage exception/CSR bundle.
- Owns the machine-mode CSR file (mstatus, mtvec, mepc, mcause, mscratch, mie, mip, optional counters) and the current privilege mode.
- Retires CSR writes, trap entries (ecall) and mret. Issues a held redirect to the fetch stage through a valid/ready handshake.
- Supplies combinational CSR read data, current mstatus and privilege back to decode/execute.

Parameters:
- MTVEC_RESET, 64'h0, reset value of mtvec.
- MSTATUS_RESET, 64'h0, reset value of mstatus.
- PRIV_RESET, 2'b11, privilege mode out of reset (M).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  instruction retiring this cycle
- wb_csr_we  in  1  retiring instruction writes a CSR
- wb_csr_addr  in  12  CSR address to write
- wb_csr_wdata  in  64  final CSR write value (set/clear already applied upstream)
- wb_trap  in  1  retiring instruction raises ecall trap
- wb_mret  in  1  retiring instruction is mret
- wb_pc  in  64  PC of retiring instruction
- wb_mcause  in  64  cause computed upstream
- wb_mstatus_new  in  64  mstatus image computed upstream for trap/mret
- wb_priv_new  in  2  privilege after trap/mret
- rd_addr  in  12  combinational read address
- rd_data  out  64  CSR read data
- mstatus_out  out  64  current mstatus
- priv_mode  out  2  current privilege
- wb_stall  out  1  upstream must hold the writeback input
- redirect_valid  out  1  fetch redirect pending
- redirect_pc  out  64  redirect target
- redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (async, any state):
  - mstatus=MSTATUS_RESET, mtvec=MTVEC_RESET, priv_mode=PRIV_RESET.
  - mepc, mcause, mscratch, mie, mip and counters = 0.
  - FSM=IDLE, redirect_valid=0, redirect_pc=0, wb_stall=0.
- A reset mid-REDIRECT drops the pending redirect.
- FSM states are IDLE and REDIRECT. Commits are accepted only in IDLE with wb_valid=1.
- IDLE, wb_valid=1, wb_trap=1, at the next edge:
  - mepc=wb_pc, mcause=wb_mcause, mstatus=wb_mstatus_new, priv_mode=wb_priv_new.
  - redirect_pc={mtvec[63:2],2'b00} (direct mode only). This uses mtvec from before the edge.
  - redirect_valid=1, go to REDIRECT.
- IDLE, wb_mret=1: mstatus=wb_mstatus_new, priv_mode=wb_priv_new, redirect_pc=mepc (pre-edge value), redirect_valid=1, go to REDIRECT.
- Priority when several flags are set: wb_trap over wb_mret over wb_csr_we. A trap suppresses a same-cycle CSR write.
- CSR write (IDLE, wb_csr_we, no trap/mret): 1-cycle write latency.
  - Addresses: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344.
  - mepc write forces bits [1:0]=0.
  - Writes to unknown addresses are dropped.
  - A CSR write does not cause a redirect.
- REDIRECT:
  - redirect_valid and redirect_pc are held stable and wb_stall=1.
  - On redirect_ready=1: next cycle redirect_valid=0, wb_stall=0, return to IDLE.
  - Inputs arriving while stalled are ignored.
- rd_data is combinational from current register state. There is no write bypass: a read of the address being written this cycle returns the old value. Unknown addresses read 0.
- mstatus_out and priv_mode reflect register state and change only at clock edges.

Optional Feature:
- Macro CSR_COUNTERS_EN.
- Defined:
  - mcycle (0xB00) increments every cycle out of reset.
  - minstret (0xB02) increments on each accepted commit (wb_valid in IDLE), including trap/mret.
  - Both are readable and writable. A software write on the same cycle wins over the increment.
  - Both wrap from all-ones to 0.
- Undefined: no counter registers; 0xB00 and 0xB02 read 0 and writes are dropped.

Test Plan:
- Assert reset mid-cycle -> immediately mstatus_out=0, priv_mode=2'b11, redirect_valid=0; rd_addr=0x305 reads MTVEC_RESET.
- CSR write 0x305 with 64'h8000_0100, then trap (wb_pc=64'h8000_0040, wb_mcause=8, wb_priv_new=3):
  - Next cycle redirect_valid=1, redirect_pc=64'h8000_0100.
  - rd 0x341=64'h8000_0040, rd 0x342=8, wb_stall=1.
- Hold redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stable, wb_stall=1, and a wb_csr_we to 0x340 during the hold is ignored (reads 0). Then redirect_ready=1 -> IDLE next cycle.
- mret with mepc=64'h8000_0044, wb_priv_new=0 -> redirect_pc=64'h8000_0044, priv_mode=0 after the edge.
- Same cycle wb_trap=1 and wb_csr_we=1 to 0x340 -> trap taken, mscratch unchanged. Separately, a write of 64'h...07 to 0x341 reads back 64'h...04.
- CSR_COUNTERS_EN: write mcycle=64'hFFFF_FFFF_FFFF_FFFF -> reads 0 the following cycle. minstret counts 5 after 5 accepted commits.
